// File: rtl/param_tensor_stream_source.sv
// param_tensor_stream_source
// Streams a constant tensor (weights/biases) from an external synchronous ROM
// as PAR-element beats over valid/ready, REPEAT passes per frame. ROM reads
// are prefetched only when the output FIFO has a guaranteed free slot, which
// counts reads still in flight through the ROM pipeline.
// Optional build macro: PARAM_SRC_CONTINUOUS_EN -- once started, frames stream
// back-to-back forever (only rst returns to IDLE).
module param_tensor_stream_source #(
    parameter int DATA_WIDTH  = 16,
    parameter int PAR         = 4,
    parameter int DEPTH       = 8,
    parameter int REPEAT      = 4,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = ROM_LATENCY + 2,
    // address width is kept at least 1 bit so DEPTH=1 still has a legal port
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      rom_en,
    output logic [AW-1:0]             rom_addr,
    input  logic [DATA_WIDTH*PAR-1:0] rom_data,
    output logic [DATA_WIDTH*PAR-1:0] data_out,
    output logic                      data_out_valid,
    input  logic                      data_out_ready,
    output logic                      data_out_last
);

    localparam int TOTAL = DEPTH * REPEAT;
    localparam int BW    = DATA_WIDTH * PAR;
    localparam int PSW   = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int OW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int FPW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);

    localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [PSW-1:0] PASS_LAST = PSW'(REPEAT - 1);
    localparam logic [OW-1:0]  BEAT_LAST = OW'(TOTAL - 1);
    localparam logic [FPW-1:0] PTR_LAST  = FPW'(FIFO_DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [AW-1:0]          addr;
    logic [PSW-1:0]         pass;
    logic                   issue_done;
    logic [ROM_LATENCY-1:0] trk;
    logic [BW-1:0]          mem [FIFO_DEPTH];
    logic [FPW-1:0]         wr_ptr;
    logic [FPW-1:0]         rd_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          inflight;
    logic [OW-1:0]          out_cnt;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   frame_end;

    // Reads still travelling through the ROM pipeline reserve FIFO space.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CW'(trk[i]);
        end
    end

    // Issue, FIFO and handshake decodes; outputs depend on registers only.
    always_comb begin
        issue          = (state == RUN) && !issue_done &&
                         ((count + inflight) < CW'(FIFO_DEPTH));
        push           = trk[ROM_LATENCY-1];
        data_out_valid = (count != '0);
        pop            = data_out_valid && data_out_ready;
        frame_end      = pop && (out_cnt == BEAT_LAST);
        busy           = (state == RUN);
        rom_en         = issue;
        rom_addr       = addr;
        data_out       = data_out_valid ? mem[rd_ptr] : '0;
        data_out_last  = data_out_valid && (out_cnt == BEAT_LAST);
    end

    // Control FSM, address/pass sequencing, in-flight tracker and output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            pass       <= '0;
            issue_done <= 1'b0;
            trk        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: begin
`ifndef PARAM_SRC_CONTINUOUS_EN
                    if (frame_end) begin
                        state      <= IDLE;
                        issue_done <= 1'b0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase

            trk[0] <= issue;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                trk[i] <= trk[i-1];
            end

            if (issue) begin
                if (addr == ADDR_LAST) begin
                    addr <= '0;
                    if (pass == PASS_LAST) begin
                        pass <= '0;
`ifndef PARAM_SRC_CONTINUOUS_EN
                        issue_done <= 1'b1;
`endif
                    end else begin
                        pass <= pass + 1'b1;
                    end
                end else begin
                    addr <= addr + 1'b1;
                end
            end

            if (push) begin
                mem[wr_ptr] <= rom_data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                out_cnt <= (out_cnt == BEAT_LAST) ? '0 : out_cnt + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Credit accounting must keep FIFO plus pipeline within FIFO capacity.
    occupancy_bound: assert property (@(posedge clk) disable iff (rst)
        (count + inflight) <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_param_tensor_stream_source.sv
// Scoreboard bench for param_tensor_stream_source: the stimulus pushes the
// expected beat sequence, a negedge monitor pops it on every handshake.
module tb_param_tensor_stream_source;

    localparam int DW    = 16;
    localparam int PAR   = 4;
    localparam int DEPTH = 8;
    localparam int REP   = 4;
    localparam int L     = 2;
    localparam int FD    = L + 2;
    localparam int TOTAL = DEPTH * REP;
    localparam int BW    = DW * PAR;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [BW-1:0] rom_data;
    logic [BW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          data_out_last;

    param_tensor_stream_source #(
        .DATA_WIDTH(DW), .PAR(PAR), .DEPTH(DEPTH), .REPEAT(REP),
        .ROM_LATENCY(L), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_last(data_out_last)
    );

    always #5 clk = ~clk;

    // ROM word k: element j = k*256 + j
    function automatic logic [BW-1:0] word(input int unsigned k);
        logic [BW-1:0] w;
        for (int j = 0; j < PAR; j++) w[DW*j +: DW] = DW'(k * 256 + j);
        return w;
    endfunction

    // synchronous ROM model with L cycles of latency
    logic [AW-1:0] apipe [L];
    logic [L-1:0]  epipe = '0;
    always @(posedge clk) begin
        apipe[0] <= rom_addr;
        epipe[0] <= rom_en;
        for (int i = 1; i < L; i++) begin
            apipe[i] <= apipe[i-1];
            epipe[i] <= epipe[i-1];
        end
    end
    always_comb rom_data = epipe[L-1] ? word(32'(apipe[L-1])) : {PAR{16'hDEAD}};

    typedef struct packed { logic [BW-1:0] d; logic l; } beat_t;
    beat_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int beats    = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // monitor: stall stability and scoreboard pop on each handshake
    logic          stall_prev = 1'b0;
    logic [BW-1:0] d_prev;
    logic          l_prev;
    beat_t         e;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {data_out_valid, data_out_last, data_out}, {1'b1, l_prev, d_prev});
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data %h last %b, expected no beat", data_out, data_out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", data_out, e.d);
                    chk("beat_last", data_out_last, e.l);
                end
                beats++;
            end
            stall_prev = data_out_valid && !data_out_ready;
            d_prev     = data_out;
            l_prev     = data_out_last;
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) if (rand_ready) #1 data_out_ready = 1'($urandom_range(0, 1));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frames(input int nf);
        for (int b = 0; b < nf * TOTAL; b++)
            exp_q.push_back('{d: word(b % DEPTH), l: ((b % TOTAL) == TOTAL - 1)});
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin step(1); n++; end
        chk(nm, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        int n_en;
        rst = 1'b1; start = 1'b0; data_out_ready = 1'b0;
        step(3);
        chk("reset_out", {busy, rom_en, data_out_valid, data_out_last, rom_addr, data_out}, 0);
        rst = 1'b0;

        // test 1: idle without start, ready toggling has no effect
        for (int k = 0; k < 10; k++) begin
            data_out_ready = k[0];
            @(negedge clk);
            chk("idle_quiet", {busy, rom_en, data_out_valid, data_out_last}, 0);
            step(1);
        end

`ifndef PARAM_SRC_CONTINUOUS_EN
        // test 2: full-rate frame, latency and last timing
        data_out_ready = 1'b1;
        push_frames(1);
        b0 = beats;
        start = 1'b1;
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            if (k == 0)  chk("t2_c0", {busy, rom_en, data_out_valid}, 0);
            if (k == 1)  chk("t2_first_issue", {busy, rom_en, rom_addr}, {1'b1, 1'b1, 3'd0});
            if (k == 3)  chk("t2_c3_valid", data_out_valid, 0);
            if (k == 4)  chk("t2_first_valid", {data_out_valid, data_out}, {1'b1, word(0)});
            if (k >= 4 && k <= 35) chk("t2_no_bubble", data_out_valid, 1);
            if (k == 34) chk("t2_not_last", data_out_last, 0);
            if (k == 35) chk("t2_last_beat", {data_out_valid, data_out_last, busy}, 3'b111);
            if (k == 36) chk("t2_idle_after", {busy, data_out_valid}, 0);
            step(1);
            if (k == 0) start = 1'b0;
        end
        chk("t2_beats", beats - b0, TOTAL);
        chk("t2_drain", exp_q.size(), 0);

        // test 4: permanent backpressure, credit limit on issue
        data_out_ready = 1'b0;
        pulse_start;
        n_en = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rom_en) n_en++;
            step(1);
        end
        @(negedge clk);
        chk("t4_issue_count", n_en, FD);
        chk("t4_hold", {rom_en, data_out_valid, data_out_last, data_out}, {1'b0, 1'b1, 1'b0, word(0)});
        step(1);
        rst = 1'b1;
        step(2);
        exp_q.delete();
        rst = 1'b0;
        step(1);

        // test 3: random ready over repeated frames, start during RUN ignored
        rand_ready = 1'b1;
        for (int f = 0; f < 14; f++) begin
            push_frames(1);
            pulse_start;
            if (f % 3 == 0) begin
                step(10);
                pulse_start;
            end
            wait_idle("t3_frame_done", 400);
        end
        rand_ready = 1'b0;
        step(1);
        data_out_ready = 1'b1;
        step(2);
        chk("t3_drain", exp_q.size(), 0);

        // test 5: reset mid-frame, late ROM data discarded, clean restart
        push_frames(1);
        b0 = beats;
        pulse_start;
        n = 0;
        while (beats < b0 + 10 && n < 100) begin @(posedge clk); n++; end
        #1;
        chk("t5_reach_10", beats - b0, 10);
        rst = 1'b1;
        step(1);
        exp_q.delete();
        chk("t5_after_rst", {busy, rom_en, data_out_valid, data_out_last, rom_addr, data_out}, 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t5_no_late", {busy, data_out_valid}, 0);
            step(1);
        end
        push_frames(1);
        pulse_start;
        chk("t5_restart_addr", {rom_en, rom_addr}, {1'b1, 3'd0});
        wait_idle("t5_frame_done", 200);
        chk("t5_drain", exp_q.size(), 0);
`else
        // test 6: continuous mode, three back-to-back frames
        data_out_ready = 1'b1;
        push_frames(4);
        b0 = beats;
        pulse_start;
        step(2);
        for (int k = 4; k < 100; k++) begin
            step(1);
            if (k == 50) start = 1'b1;
            if (k == 51) start = 1'b0;
            chk("t6_stream", {busy, data_out_valid}, 2'b11);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        chk("t6_beats", beats - b0, 3 * TOTAL);
        step(2);
        exp_q.delete();
        rst = 1'b0;
        chk("t6_rst_idle", {busy, data_out_valid}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
